// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
// Optional feature macro used by the converter: BCD_CHECK_EN.
package bcd2bin_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX        = 4'd9;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ        = 4'd3;

  // Smallest binary width that holds every value of n_digits decimal digits.
  function automatic int min_bin_w(input int n_digits);
    longint unsigned range_v;
    range_v = 1;
    for (int i = 0; i < n_digits; i++) begin
      range_v = range_v * 10;
    end
    return $clog2(range_v);
  endfunction

endpackage

// File: rtl/bcd2bin_seq_digit_adj.sv
// One BCD digit correction step of reverse double-dabble: d >= 8 ? d - 3 : d.
// Purely combinational.
module bcd_digit_adj
  import bcd2bin_pkg::*;
(
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);

  always_comb begin
    d_out = (d_in >= BCD_ADJ_THRESH) ? (d_in - BCD_ADJ) : d_in;
  end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift per cycle), valid/ready in and out.
// Macro BCD_CHECK_EN: reject inputs with a digit > 9 (bin_out=0, err=1, one-cycle latency).
module bcd2bin_seq
  import bcd2bin_pkg::*;
#(
  parameter int N_DIGITS = 2,
  parameter int BIN_W    = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int DIG_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (BIN_W < min_bin_w(N_DIGITS)) begin : g_bin_w_too_small
    $error("bcd2bin_seq: BIN_W too small for N_DIGITS");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIG_W-1:0]   dig_q, dig_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BIN_W-1:0]   res_q, res_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [DIG_W-1:0]   dig_shift, dig_adj;
  logic [BIN_W-1:0]   bin_shift;

  // The {digits, bin} pair moves right as one register; digit-0 LSB feeds the bin MSB.
  assign dig_shift = {1'b0, dig_q[DIG_W-1:1]};
  assign bin_shift = {dig_q[0], bin_q[BIN_W-1:1]};

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_in  (dig_shift[4*g +: 4]),
      .d_out (dig_adj[4*g +: 4])
    );
  end

`ifdef BCD_CHECK_EN
  logic bcd_in_bad;
  logic bad_q, bad_d;
  logic err_q, err_d;

  always_comb begin
    bcd_in_bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > BCD_MAX) bcd_in_bad = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    bin_d   = bin_q;
    res_d   = res_q;
`ifdef BCD_CHECK_EN
    bad_d   = bad_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dig_d   = bcd_in;
          bin_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = SHIFT;
`ifdef BCD_CHECK_EN
          bad_d   = bcd_in_bad;
          err_d   = 1'b0;
          // A zero count lets a bad operand fall through to DONE on the next edge with bin still 0.
          if (bcd_in_bad) cnt_d = '0;
`endif
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          dig_d = dig_adj;
          bin_d = bin_shift;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          res_d   = bin_q;
          state_d = DONE;
`ifdef BCD_CHECK_EN
          err_d   = bad_q;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dig_q       <= '0;
      bin_q       <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef BCD_CHECK_EN
      bad_q       <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      bin_q       <= bin_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef BCD_CHECK_EN
      bad_q       <= bad_d;
      err_q       <= err_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bin_out   = res_q;
`ifdef BCD_CHECK_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Randomized and directed bench for bcd2bin_seq against a transaction-level timing/value model.
// Honors BCD_CHECK_EN the same way the design does.
module tb_bcd2bin_seq;

  localparam int N_DIGITS = 2;
  localparam int BIN_W    = 7;
  localparam int LAT      = BIN_W + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       bcd_in = 8'h00;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [BIN_W-1:0] bin_out;
  logic             err;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  bcd2bin_seq #(.N_DIGITS(N_DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int bcd_value(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit bcd_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  // Transaction model: idle -> busy for a fixed latency -> holding result until consumed.
  bit               m_idle = 1'b1, m_done = 1'b0, m_err = 1'b0, m_known = 1'b1;
  bit               p_known, p_err;
  int               m_wait = 0;
  logic [BIN_W-1:0] m_bin = '0, p_bin;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_idle = 1'b1; m_done = 1'b0; m_wait = 0;
      m_bin = '0; m_err = 1'b0; m_known = 1'b1;
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle  = 1'b0;
        m_err   = 1'b0;
        p_bin   = BIN_W'(bcd_value(bcd_in));
        p_known = bcd_ok(bcd_in);
        p_err   = 1'b0;
        m_wait  = LAT;
`ifdef BCD_CHECK_EN
        if (!p_known) begin
          p_bin = '0; p_err = 1'b1; p_known = 1'b1; m_wait = 1;
        end
`endif
      end
    end else if (!m_done) begin
      m_wait--;
      if (m_wait == 0) begin
        m_done = 1'b1; m_bin = p_bin; m_err = p_err; m_known = p_known;
      end
    end else if (out_ready) begin
      m_done = 1'b0;
      m_idle = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_in_ready", in_ready, m_idle);
      chk("mdl_out_valid", out_valid, m_done);
      chk("mdl_err", err, m_err);
      if (m_known) chk("mdl_bin_out", bin_out, m_bin);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    if (!in_ready) chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_idle();
    in_valid = 1'b1;
    bcd_in   = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    if (!out_valid) chk("wait_out_timeout", 0, 1);
  endtask

  initial begin
    int c;
    logic [7:0] b;

    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bin_out", bin_out, 0);
    chk("rst_err", err, 0);

    // Basic conversion and latency, one-cycle output pulse.
    out_ready = 1'b1;
    send(8'h42);
    wait_out(c);
    chk("basic_lat", c, 8);
    chk("basic_bin", bin_out, 42);
    step();
    chk("basic_pulse", out_valid, 0);
    chk("basic_hold", bin_out, 42);

    // Every valid two-digit BCD value.
    for (int v = 0; v < 100; v++) begin
      b = {4'(v / 10), 4'(v % 10)};
      send(b);
      wait_out(c);
      chk("sweep_lat", c, 8);
      chk("sweep_bin", bin_out, v);
      chk("sweep_err", err, 0);
    end

    // Backpressure: result held, new input ignored.
    step();
    out_ready = 1'b0;
    send(8'h99);
    wait_out(c);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      bcd_in   = 8'h33;
      step();
      chk("bp_bin", bin_out, 99);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release", out_valid, 0);

    // Retire and offer a new input on the same edge.
    out_ready = 1'b0;
    send(8'h25);
    wait_out(c);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    bcd_in    = 8'h10;
    step();
    chk("sim_no_accept", in_ready, 1);
    chk("sim_retired", out_valid, 0);
    step();
    in_valid = 1'b0;
    chk("sim_accepted", in_ready, 0);
    wait_out(c);
    chk("sim_lat", c, 8);
    chk("sim_bin", bin_out, 10);

    // Invalid digit handling.
    send(8'h1A);
    wait_out(c);
`ifdef BCD_CHECK_EN
    chk("bad_lat", c, 1);
    chk("bad_err", err, 1);
    chk("bad_bin", bin_out, 0);
`else
    chk("bad_lat", c, 8);
    chk("bad_err", err, 0);
`endif
    send(8'h05);
    chk("bad_err_clear", err, 0);
    wait_out(c);
    chk("after_bad_bin", bin_out, 5);
    chk("after_bad_err", err, 0);
    chk("after_bad_lat", c, 8);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) bcd_in = 8'($urandom);
      else bcd_in = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();

    // Reset in the middle of a conversion.
    send(8'h57);
    repeat (3) step();
    chk("rst_mid_busy", in_ready, 0);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_bin_out", bin_out, 0);
    chk("rst_mid_err", err, 0);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("rst_no_result", out_valid, 0);
    end
    chk("rst_final_bin", bin_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
